// File: rtl/fp_mult_seq_if.sv
// Operand/result handshake bundle for fp_mult_seq; master = producer/consumer side, slave = multiplier.
interface fp_mult_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/fp_mult_seq.sv
// Iterative IEEE-754-style multiplier (FTZ, RNE); result valid MAN_W+3 edges after accept.
// One op in flight: in_ready only in IDLE, result/flags held in DONE until out_ready.
module fp_mult_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic          clk,
    input  logic          rst_n,
    fp_mult_seq_if.slave  bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int N  = MAN_W + 1;
    localparam int CW = (MAN_W + 1 > 1) ? $clog2(MAN_W + 1) : 1;
    localparam int XW = EXP_W + 2;

    localparam logic [XW-1:0]        BIAS_X  = XW'((2 ** (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EXP_INF = XW'((2 ** EXP_W) - 1);
    localparam logic signed [XW-1:0] EXP_ONE = XW'(1);
    localparam logic [CW-1:0]        CNT_END = CW'(MAN_W);
    localparam logic [W-1:0]         QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, UNPACK, MUL, ROUND, DONE} state_t;

    state_t                 state;
    logic [W-1:0]           a_q, b_q;
    logic                   sign_q;
    logic signed [XW-1:0]   exp_q;
    logic [N-1:0]           mcand_q;
    logic [2*N-1:0]         prod_q;
    logic [CW-1:0]          cnt_q;
    logic                   a_zero_q, a_inf_q, a_nan_q, a_snan_q;
    logic                   b_zero_q, b_inf_q, b_nan_q, b_snan_q;
    logic [W-1:0]           result_q;
    logic [3:0]             flags_q;
    logic                   out_valid_q;
    logic                   in_ready_q;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

    // Operand field decode, consumed in UNPACK
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             ea_max, eb_max, ea_zero, eb_zero, fa_nz, fb_nz;
    logic [XW-1:0]    exp_sum;

    assign ea      = a_q[W-2:MAN_W];
    assign eb      = b_q[W-2:MAN_W];
    assign fa      = a_q[MAN_W-1:0];
    assign fb      = b_q[MAN_W-1:0];
    assign ea_max  = &ea;
    assign eb_max  = &eb;
    assign ea_zero = ~|ea;
    assign eb_zero = ~|eb;
    assign fa_nz   = |fa;
    assign fb_nz   = |fb;
    assign exp_sum = {2'b00, ea} + {2'b00, eb} - BIAS_X;

    // Right-shift accumulate: the low half starts as the multiplier and drains one bit per cycle
    logic [N:0] mul_sum;
    assign mul_sum = {1'b0, prod_q[2*N-1:N]} + (prod_q[0] ? {1'b0, mcand_q} : {(N+1){1'b0}});

    logic [N-1:0]         norm_man;
    logic                 guard, sticky, round_up;
    logic signed [XW-1:0] norm_exp, fin_exp;
    logic [N:0]           rnd_sum;
    logic [MAN_W-1:0]     fin_frac;
    logic                 any_nan, any_snan, any_inf, any_zero, inf_zero;
    logic [W-1:0]         res_n;
    logic [3:0]           flags_n;

    always_comb begin
        norm_man = '0;
        guard    = 1'b0;
        sticky   = 1'b0;
        norm_exp = exp_q;
        if (prod_q[2*N-1]) begin
            norm_man = prod_q[2*N-1:N];
            guard    = prod_q[N-1];
            sticky   = |prod_q[N-2:0];
            norm_exp = exp_q + EXP_ONE;
        end else begin
            norm_man = prod_q[2*N-2:N-1];
            guard    = prod_q[N-2];
            sticky   = |prod_q[N-3:0];
        end

        round_up = guard & (sticky | norm_man[0]);
        rnd_sum  = {1'b0, norm_man} + {{N{1'b0}}, round_up};
        if (rnd_sum[N]) begin
            fin_frac = rnd_sum[N-1:1];
            fin_exp  = norm_exp + EXP_ONE;
        end else begin
            fin_frac = rnd_sum[MAN_W-1:0];
            fin_exp  = norm_exp;
        end

        any_nan  = a_nan_q | b_nan_q;
        any_snan = a_snan_q | b_snan_q;
        any_inf  = a_inf_q | b_inf_q;
        any_zero = a_zero_q | b_zero_q;
        inf_zero = (a_inf_q & b_zero_q) | (b_inf_q & a_zero_q);

        res_n   = '0;
        flags_n = '0;
        if (any_nan) begin
            res_n   = QNAN;
            flags_n = {any_snan, 3'b000};
        end else if (inf_zero) begin
            res_n   = QNAN;
            flags_n = 4'b1000;
        end else if (any_inf) begin
            res_n   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (any_zero) begin
            res_n   = {sign_q, {(W-1){1'b0}}};
        end else if (fin_exp >= EXP_INF) begin
            res_n   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_n = 4'b0101;
        end else if (fin_exp <= 0) begin
            res_n   = {sign_q, {(W-1){1'b0}}};
            flags_n = 4'b0011;
        end else begin
            res_n   = {sign_q, fin_exp[EXP_W-1:0], fin_frac};
            flags_n = {3'b000, guard | sticky};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mcand_q     <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            a_zero_q    <= 1'b0;
            a_inf_q     <= 1'b0;
            a_nan_q     <= 1'b0;
            a_snan_q    <= 1'b0;
            b_zero_q    <= 1'b0;
            b_inf_q     <= 1'b0;
            b_nan_q     <= 1'b0;
            b_snan_q    <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        in_ready_q <= 1'b0;
                        state      <= UNPACK;
                    end
                end
                UNPACK: begin
                    sign_q   <= a_q[W-1] ^ b_q[W-1];
                    exp_q    <= $signed(exp_sum);
                    mcand_q  <= {1'b1, fa};
                    prod_q   <= {{N{1'b0}}, 1'b1, fb};
                    cnt_q    <= '0;
                    // Denormals flush to zero along with true zeros
                    a_zero_q <= ea_zero;
                    a_inf_q  <= ea_max & ~fa_nz;
                    a_nan_q  <= ea_max & fa_nz;
                    a_snan_q <= ea_max & fa_nz & ~fa[MAN_W-1];
                    b_zero_q <= eb_zero;
                    b_inf_q  <= eb_max & ~fb_nz;
                    b_nan_q  <= eb_max & fb_nz;
                    b_snan_q <= eb_max & fb_nz & ~fb[MAN_W-1];
                    state    <= MUL;
                end
                MUL: begin
                    prod_q <= {mul_sum, prod_q[N-1:1]};
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CNT_END) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    result_q    <= res_n;
                    flags_q     <= flags_n;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/fp_mult_seq.md
Name: fp_mult_seq

Overview:
- Parametrised, sequential IEEE-754-style floating-point multiplier. It succeeds the combinational single-precision Mult.
- Adds generic exponent/mantissa widths, a valid/ready handshake on both sides, an iterative shift-add significand multiplier, round-to-nearest-even, special-value handling and exception flags.
- Sits between operand-producing datapath stages and result consumers wherever a full combinational multiplier costs too much area.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 23, stored fraction width; word width W = 1+EXP_W+MAN_W (defaults give binary32)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a/b valid
in_ready  output  1  block can accept operands
a  input  W  operand A {sign, exp, frac}
b  input  W  operand B
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  W  product
flags  output  4  {invalid, overflow, underflow, inexact}

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: state IDLE, in_ready=1, out_valid=0, result=0, flags=0, all internal registers cleared. Asserting reset mid-operation aborts the operation and discards the result.
- FSM states: IDLE, UNPACK, MUL, ROUND, DONE. in_ready = (state==IDLE).
- IDLE→UNPACK: on in_valid&&in_ready; a and b are registered.
- UNPACK (1 cycle):
  - classify each operand as zero, denormal, inf, qNaN, sNaN or normal; denormals are treated as signed zero (flush-to-zero);
  - sign = sa^sb;
  - exponent sum ea+eb-bias, held in an (EXP_W+2)-bit signed register;
  - significands with hidden 1 (MAN_W+1 bits).
- UNPACK→MUL.
- MUL (exactly MAN_W+1 cycles):
  - each cycle examines one multiplier bit, LSB first, and conditionally adds the multiplicand into a 2*(MAN_W+1)-bit partial product (right-shift accumulate);
  - a counter runs 0..MAN_W; MUL→ROUND when the counter reaches MAN_W.
- ROUND (1 cycle), normalise then round:
  - normalise: if product MSB=1, take the upper MAN_W+1 bits and exp+1; otherwise shift left by 1;
  - guard = next bit, sticky = OR of all remaining lower bits;
  - round up when guard && (sticky || lsb);
  - a rounding carry-out renormalises and increments exp.
  - Final biased exp >= 2^EXP_W-1 → signed inf, overflow=1, inexact=1.
  - Final exp <= 0 → signed zero, underflow=1, inexact=1.
  - Otherwise inexact = guard|sticky.
- Special cases, resolved in ROUND (latency unchanged, significand ignored):
  - any NaN input → canonical qNaN (sign 0, exp all ones, frac MSB 1, rest 0); invalid=1 if either input is sNaN;
  - inf×0 → canonical qNaN, invalid=1;
  - inf×nonzero → signed inf, flags 0;
  - zero×finite → signed zero, flags 0.
- ROUND→DONE: result and flags are registered; out_valid=1.
- DONE:
  - result and flags are held stable while out_valid && !out_ready;
  - on out_ready: out_valid=0 next cycle, DONE→IDLE.
- Latency: out_valid rises MAN_W+3 clock edges after the accepting edge (26 for defaults).
- Throughput: one operation per MAN_W+5 cycles at minimum.
- in_valid seen while busy is ignored; the producer must hold it until in_ready.

Test Plan:
1. Defaults; a=0x3F800000 (1.0), b=0x4083288D (4.0987) → result 0x4083288D, flags 0, out_valid exactly 26 cycles after accept.
2. 0x40000000×0x40400000 → 0x40C00000; 0xC0000000×0x40400000 → 0xC0C00000; 0x3FC00000×0x3FC00000 → 0x40100000; all flags 0.
3. Rounding:
   - 0x3F800001×0x3F800001 → 0x3F800002, inexact=1;
   - tie-to-even 0x3F800001×0x3FC00000 → 0x3FC00002, inexact=1.
4. Exceptions:
   - 0x7F000000×0x40000000 → 0x7F800000, flags 0b0101;
   - 0x00800000×0x3F000000 → 0x00000000, flags 0b0011;
   - 0x7F800000×0x00000000 → 0x7FC00000, flags 0b1000;
   - 0x7F800001×0x3F800000 → 0x7FC00000, invalid=1.
5. Back-pressure: hold out_ready=0 for 10 cycles after out_valid → result, flags and out_valid stable and in_ready=0; release → in_ready=1 one cycle after the handshake.
6. Reset and width:
   - pulse rst_n low during MUL → out_valid=0, in_ready=1 immediately; the next operation 1.0×1.0 → 0x3F800000;
   - repeat scenarios 1–2 with EXP_W=11, MAN_W=52 (1.0×x=x, 2.0×3.0=0x4018000000000000), latency 55.
